// File: rtl/bfm_ahbslave_mem_ws.sv
// AHB-Lite slave memory model with programmable wait states,
// byte-lane writes and two-cycle ERROR responses.
module bfm_ahbslave_mem_ws #(
    parameter int                AWIDTH = 10,
    parameter int                DWIDTH = 32,
    parameter int                DEPTH  = 256,
    parameter logic [AWIDTH-1:0] ERRLO  = 'h3F0,
    parameter logic [AWIDTH-1:0] ERRHI  = 'h3FF
) (
    input  logic              HCLK,
    input  logic              HRESETN,
    input  logic              HSEL,
    input  logic [AWIDTH-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DWIDTH-1:0] HWDATA,
    input  logic              HREADYIN,
    input  logic [3:0]        WAITCFG,
    output logic [DWIDTH-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int NB = DWIDTH / 8;
    localparam int BL = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = BL + IW;
    localparam bit WIN_EN = (ERRLO <= ERRHI);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [LW-1:0]     addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [DWIDTH-1:0] rdata_q;
    logic              load;
    logic              accept;
    logic              err;
    logic              in_win;
    logic              too_big;
    logic              misalign;
    logic [7:0]        sz_bytes;
    logic [7:0]        addr_lo;
    logic [IW-1:0]     idx_q;
    logic [NB-1:0]     lane_en;
    logic              rd_now;
    logic              wr_now;
    logic              burst_unused;

    logic [DWIDTH-1:0] mem [DEPTH];

    assign burst_unused = ^HBURST;

    assign accept   = HSEL & HREADYIN & HTRANS[1];
    assign sz_bytes = 8'd1 << HSIZE;
    assign addr_lo  = HADDR[7:0];
    assign too_big  = HSIZE > 3'(BL);
    assign misalign = (addr_lo & (sz_bytes - 8'd1)) != 8'd0;
    assign in_win   = WIN_EN && (HADDR >= ERRLO) && (HADDR <= ERRHI);
    assign err      = in_win | too_big | misalign;

    assign idx_q  = addr_q[LW-1:BL];
    assign rd_now = (state_q == S_DATA) && !write_q;
    assign wr_now = (state_q == S_DATA) && write_q;

    // Next state: accepts are only honoured while this slave is ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DATA, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    load = 1'b1;
                    if (err) begin
                        state_d = S_ERR1;
                    end else if (WAITCFG != 4'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAITCFG;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DATA;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                addr_q  <= HADDR[LW-1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
            if (rd_now) begin
                rdata_q <= mem[idx_q];
            end
        end
    end

    // Little-endian lane select from the latched size and offset.
    always_comb begin
        lane_en = '0;
        for (int b = 0; b < NB; b++) begin
            lane_en[b] = (b >= int'(addr_q[BL-1:0])) &&
                         (b < int'(addr_q[BL-1:0]) + (1 << size_q));
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETN && wr_now) begin
            for (int b = 0; b < NB; b++) begin
                if (lane_en[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data is live during the completing cycle so a write
    // landing on the previous edge is visible.
    assign HRDATA    = rd_now ? mem[idx_q] : rdata_q;
    assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);

endmodule
